// File: rtl/pipe_hold_sched.sv
// pipe_hold_sched: sequenced hold/flush/halt scheduler feeding pc_reg, if_id and id_ex
module pipe_hold_sched #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_ex_i,
    input  logic              hold_rib_i,
    input  logic              dbg_halt_req_i,
    output logic [2:0]        hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              dbg_halted_o,
    output logic              halt_timeout_o
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(HALT_TIMEOUT + 1);
    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    typedef enum logic [2:0] {RUN, FLUSH, HALT_PEND, HALTED, RESUME} state_t;

    state_t          state, state_n;
    logic [FW-1:0]   flush_cnt, flush_n;
    logic [TW-1:0]   to_cnt, to_n;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_n;
            to_cnt    <= to_n;
        end
    end

    // Next-state and outputs; reset masks every output in the same cycle
    always_comb begin
        state_n        = state;
        flush_n        = flush_cnt;
        to_n           = to_cnt;
        hold_flag_o    = HOLD_NONE;
        jump_flag_o    = 1'b0;
        jump_addr_o    = '0;
        dbg_halted_o   = 1'b0;
        halt_timeout_o = 1'b0;
        case (state)
            RUN: begin
                hold_flag_o = (jump_flag_i || hold_ex_i) ? HOLD_ID : (hold_rib_i ? HOLD_PC : HOLD_NONE);
                jump_flag_o = jump_flag_i;
                jump_addr_o = jump_addr_i;
                if (jump_flag_i && FLUSH_CYCLES > 1) begin
                    flush_n = FW'(FLUSH_CYCLES - 1);
                    state_n = FLUSH;
                end else if (dbg_halt_req_i && !jump_flag_i) begin
                    to_n    = '0;
                    state_n = HALT_PEND;
                end
            end
            FLUSH: begin
                hold_flag_o = HOLD_ID;
                jump_flag_o = jump_flag_i;
                jump_addr_o = jump_addr_i;
                if (jump_flag_i) flush_n = FW'(FLUSH_CYCLES - 1);
                else if (flush_cnt <= FW'(1)) state_n = RUN;
                else flush_n = flush_cnt - 1'b1;
            end
            HALT_PEND: begin
                hold_flag_o = HOLD_ID;
                jump_flag_o = jump_flag_i;
                jump_addr_o = jump_addr_i;
                to_n        = (to_cnt == TW'(HALT_TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
                if (!dbg_halt_req_i) state_n = RUN;
                else if (!hold_ex_i && !hold_rib_i && !jump_flag_i) state_n = HALTED;
                else if (to_cnt >= TW'(HALT_TIMEOUT - 1)) begin
                    state_n        = HALTED;
                    halt_timeout_o = 1'b1;
                end
            end
            HALTED: begin
                hold_flag_o  = HOLD_ID;
                dbg_halted_o = 1'b1;
                if (!dbg_halt_req_i) state_n = RESUME;
            end
            RESUME: begin
                hold_flag_o = HOLD_ID;
                state_n     = RUN;
            end
            default: state_n = RUN;
        endcase
        if (rst) begin
            hold_flag_o    = HOLD_NONE;
            jump_flag_o    = 1'b0;
            jump_addr_o    = '0;
            dbg_halted_o   = 1'b0;
            halt_timeout_o = 1'b0;
        end
    end
endmodule
